// File: rtl/reg_bus_xfer_ctrl.sv
// Register-bus transfer sequencer: one source-to-sink move at a time over the shared 8-bit bus.
// Optional macro BUS_TURNAROUND_EN inserts a dead TURN cycle after every transfer.
module reg_bus_xfer_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk50M_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [IDX_W-1:0]    req_src_i,
  input  logic                req_src_ext_i,
  input  logic [IDX_W-1:0]    req_dst_i,
  input  logic                req_dst_ext_i,
  output logic [NUM_REGS-1:0] ff_rd_o,
  output logic [NUM_REGS-1:0] ff_wr_o,
  output logic                ext_drv_o,
  output logic                ext_cap_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_NOP, S_TURN} state_t;

  localparam logic [IDX_W:0]    LP_NUM = (IDX_W+1)'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] LP_ONE = NUM_REGS'(1);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_src, r_dst, w_src_nxt, w_dst_nxt;
  logic                r_src_ext, r_dst_ext, r_err;
  logic                w_src_ext_nxt, w_dst_ext_nxt, w_err_nxt;
  logic                w_accept, w_illegal, w_null, w_drive, w_sink, w_retire;
  logic [NUM_REGS-1:0] r_rd, r_wr;
  logic                r_xd, r_xc, r_done, r_err_pls;

  assign w_illegal = (!req_src_ext_i && ({1'b0, req_src_i} >= LP_NUM)) ||
                     (!req_dst_ext_i && ({1'b0, req_dst_i} >= LP_NUM));
  assign w_null    = (req_src_ext_i && req_dst_ext_i) ||
                     (!req_src_ext_i && !req_dst_ext_i && (req_src_i == req_dst_i));

  // The retiring state also accepts, so a new request can start on the retire edge.
`ifdef BUS_TURNAROUND_EN
  assign req_ready_o = (r_state == S_IDLE) || (r_state == S_TURN);
`else
  assign req_ready_o = (r_state == S_IDLE) || (r_state == S_XFER) || (r_state == S_NOP);
`endif

  assign w_accept = req_valid_i && req_ready_o;
  assign w_retire = (r_state == S_XFER) || (r_state == S_NOP);

  always_comb begin
    w_state_nxt   = S_IDLE;
    w_src_nxt     = r_src;
    w_dst_nxt     = r_dst;
    w_src_ext_nxt = r_src_ext;
    w_dst_ext_nxt = r_dst_ext;
    w_err_nxt     = r_err;
    case (r_state)
      S_SETUP: w_state_nxt = S_XFER;
`ifdef BUS_TURNAROUND_EN
      S_XFER, S_NOP: w_state_nxt = S_TURN;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_accept) begin
      w_src_nxt     = req_src_i;
      w_dst_nxt     = req_dst_i;
      w_src_ext_nxt = req_src_ext_i;
      w_dst_ext_nxt = req_dst_ext_i;
      w_err_nxt     = w_illegal;
      w_state_nxt   = (w_illegal || w_null) ? S_NOP : S_SETUP;
    end
  end

  // Enables are registered from the next state so they change only on clock edges.
  assign w_drive = (w_state_nxt == S_SETUP) || (w_state_nxt == S_XFER);
  assign w_sink  = (w_state_nxt == S_XFER);

  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_rd      <= '0;
      r_wr      <= '0;
      r_xd      <= 1'b0;
      r_xc      <= 1'b0;
      r_done    <= 1'b0;
      r_err_pls <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd      <= (w_drive && !w_src_ext_nxt) ? (LP_ONE << w_src_nxt) : '0;
      r_wr      <= (w_sink && !w_dst_ext_nxt) ? (LP_ONE << w_dst_nxt) : '0;
      r_xd      <= w_drive && w_src_ext_nxt;
      r_xc      <= w_sink && w_dst_ext_nxt;
      r_done    <= w_retire;
      r_err_pls <= (r_state == S_NOP) && r_err;
    end
  end

  always_ff @(posedge clk50M_i) begin
    r_src     <= w_src_nxt;
    r_dst     <= w_dst_nxt;
    r_src_ext <= w_src_ext_nxt;
    r_dst_ext <= w_dst_ext_nxt;
    r_err     <= w_err_nxt;
  end

  assign ff_rd_o   = r_rd;
  assign ff_wr_o   = r_wr;
  assign ext_drv_o = r_xd;
  assign ext_cap_o = r_xc;
  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = r_done;
  assign err_o     = r_err_pls;

endmodule
